// File: rtl/pixel_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_seq_pkg
//  Description : Shared types and default constants for the pixel stream
//                sequencer and its pixel-operation stage.
//  Revision    : 1.0  initial release
// ============================================================================
package pixel_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default frame geometry
    localparam int DEF_NUM_PIX = 256;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CNT_W   = 9;

    // Largest pixel value for the default pixel width
    localparam int PIX_MAX     = 2**DEF_DATA_W - 1;

endpackage
`default_nettype wire

// File: rtl/pixel_op.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_op
//  Description : Purely combinational per-pixel operation f(x). Kept as its
//                own block so other point filters can be dropped in later.
//                Compile-time option PIXEL_INVERT_EN:
//                  defined   -> f(x) = (2**DATA_W-1) - x  (negative image)
//                  undefined -> f(x) = x                 (pass-through)
//  Ports       : pix_in  [DATA_W] pixel from the source BRAM
//                pix_out [DATA_W] processed pixel
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_op
    import pixel_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] pix_out
);

`ifdef PIXEL_INVERT_EN
    // All-ones of the configured width, so DATA_W other than 8 also works
    localparam logic [DATA_W-1:0] c_PIX_MAX = {DATA_W{1'b1}};

    assign pix_out = c_PIX_MAX - pix_in;
`else
    assign pix_out = pix_in;
`endif

endmodule
`default_nettype wire

// File: rtl/pixel_stream_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stream_seq
//  Description : On a start strobe, sweeps one frame out of the source BRAM
//                (port B), passes each pixel through pixel_op and writes it
//                to the destination BRAM (port A) at the same address, one
//                pixel per clock. Reports the number of pixels written.
//                Compile-time option PIXEL_INVERT_EN selects the negative-
//                image operation inside pixel_op.
//  Ports       : clk      system clock (rising edge)
//                reset_n  asynchronous active-low reset
//                start    one-cycle frame-start strobe
//                rd_en    source read enable
//                rd_addr  source read address
//                rd_data  source read data, RD_LAT clocks after address
//                wr_en    destination write enable
//                wr_addr  destination write address
//                wr_data  processed pixel
//                count    pixels written this frame (saturates at NUM_PIX)
//                busy     high while reading or draining
//                done     high once the frame is complete
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_stream_seq
    import pixel_seq_pkg::*;
#(
    parameter int NUM_PIX = DEF_NUM_PIX,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_PIX - 1);
    localparam logic [CNT_W-1:0]  c_NUM_PIX   = CNT_W'(NUM_PIX);

    state_t              r_state;
    state_t              w_state_nxt;

    // Read-flag / address delay line, aligned with rd_data at the last stage
    logic                r_vld      [RD_LAT];
    logic [ADDR_W-1:0]   r_dly_addr [RD_LAT];

    logic                w_pipe_busy;
    logic                w_start_ok;
    logic                w_last_rd;
    logic [DATA_W-1:0]   w_pix;

    // start only counts when the FSM is waiting for it
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_rd  = rd_en && (rd_addr == c_LAST_ADDR);

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_pipe_busy = w_pipe_busy | r_vld[i];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = READ;
            end
            READ: begin
                busy = 1'b1;
                if (w_last_rd) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Delay line empty means the final write is on the port now;
                // count reaches NUM_PIX on the same edge that enters DONE.
                if (!w_pipe_busy) w_state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = READ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read address generator. The first READ cycle only arms rd_en, so
    // address 0 is presented one clock after start is sampled. The address
    // stops at the last pixel rather than wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else if (w_start_ok) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else if (r_state == READ) begin
            if (!rd_en) begin
                rd_en <= 1'b1;
            end else if (rd_addr == c_LAST_ADDR) begin
                rd_en <= 1'b0;
            end else begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
        end else begin
            rd_en <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Delay line matching the source BRAM read latency
    // ------------------------------------------------------------------
    for (genvar i = 0; i < RD_LAT; i++) begin : g_dly
        if (i == 0) begin : g_head
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_vld[0]      <= 1'b0;
                    r_dly_addr[0] <= '0;
                end else begin
                    r_vld[0]      <= rd_en;
                    r_dly_addr[0] <= rd_addr;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_vld[i]      <= 1'b0;
                    r_dly_addr[i] <= '0;
                end else begin
                    r_vld[i]      <= r_vld[i-1];
                    r_dly_addr[i] <= r_dly_addr[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel operation and write stage
    // ------------------------------------------------------------------
    pixel_op #(
        .DATA_W (DATA_W)
    ) u_pixel_op (
        .pix_in  (rd_data),
        .pix_out (w_pix)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (r_vld[RD_LAT-1]) begin
            wr_en   <= 1'b1;
            wr_addr <= r_dly_addr[RD_LAT-1];
            wr_data <= w_pix;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Pixels written; counts the cycle after each write and saturates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (w_start_ok) begin
            count <= '0;
        end else if (wr_en && (count < c_NUM_PIX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
